// File: rtl/vchip8_fb_pkg.sv
// Shared constants, command encoding and FSM states for the vchip8 framebuffer controller.
package vchip8_fb_pkg;
    localparam int FB_W  = 64;
    localparam int FB_H  = 32;
    localparam int CMD_W = 13;

    // Field positions within the PIO command word
    localparam int PIO_TOG = 15;
    localparam int PIO_HI  = 14;
    localparam int PIO_LO  = 2;

    typedef enum logic [1:0] {
        CMD_CLR = 2'b00,
        CMD_SET = 2'b01,
        CMD_XOR = 2'b10,
        CMD_CLS = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_MOD,
        ST_WR,
        ST_CLEAR
    } state_e;

    // Same layout as pio_word[14:2]
    typedef struct packed {
        cmd_e       cmd;
        logic [5:0] x;
        logic [4:0] y;
    } fb_cmd_t;
endpackage

// File: rtl/vchip8_fb_cmd_fifo.sv
// Synchronous command FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module vchip8_fb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/vchip8_fb_ctrl.sv
// Framebuffer controller: PIO command capture, queued pixel RMW / clear engine, shared RAM with scan-out.
// Optional VCHIP8_FB_COLLISION_EN adds a sticky XOR collision flag in status[5].
module vchip8_fb_ctrl
    import vchip8_fb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [15:0]     pio_word,
    input  logic            rd_req,
    input  logic [4:0]      rd_row,
    output logic [FB_W-1:0] rd_data,
    output logic            rd_valid,
    output logic [7:0]      status
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_e          state;
    fb_cmd_t         cur, fifo_cmd;
    logic [CMD_W-1:0] fifo_raw;
    logic [4:0]      row_cnt;
    logic [FB_W-1:0] wr_row, mod_row, ram_q, ram_wdata;
    logic [FB_W-1:0] mem [FB_H];
    logic [4:0]      ram_addr;
    logic            ram_we, ram_re;
    logic            prev_toggle, overflow, collision, busy;
    logic            capture, pop, fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [31:0]     cnt32;
    logic [2:0]      count_disp;
    logic [SW-1:0]   starve_cnt;
    logic            eng_need, disp_win, eng_grant;
    logic [5:0]      bit_idx;
    logic            unused_bits;

    assign unused_bits = ^pio_word[1:0];
    assign capture     = pio_word[PIO_TOG] != prev_toggle;
    assign pop         = (state == ST_IDLE) && !fifo_empty;
    assign fifo_cmd    = fb_cmd_t'(fifo_raw);

    vchip8_fb_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (capture),
        .pop     (pop),
        .din     (pio_word[PIO_HI:PIO_LO]),
        .dout    (fifo_raw),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Display owns the RAM unless its read is in flight or the engine has been starved long enough
    assign eng_need  = state inside {ST_RD, ST_WR, ST_CLEAR};
    assign disp_win  = rd_req && !rd_valid && !(eng_need && starve_cnt == SW'(STARVE_LIMIT));
    assign eng_grant = eng_need && !disp_win;

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = rd_row;
        ram_wdata = wr_row;
        if (disp_win) begin
            ram_re = 1'b1;
        end else if (eng_grant) begin
            case (state)
                ST_RD:    begin ram_re = 1'b1; ram_addr = cur.y; end
                ST_WR:    begin ram_we = 1'b1; ram_addr = cur.y; end
                ST_CLEAR: begin ram_we = 1'b1; ram_addr = row_cnt; ram_wdata = '0; end
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    ram_q <= '0;
        else if (ram_re) ram_q <= mem[ram_addr];
    end
    assign rd_data = ram_q;

    // x=0 is the MSB, so the bit index is 63-x, i.e. the 6-bit complement of x
    assign bit_idx = ~cur.x;

    always_comb begin
        mod_row = ram_q;
        case (cur.cmd)
            CMD_CLR: mod_row[bit_idx] = 1'b0;
            CMD_SET: mod_row[bit_idx] = 1'b1;
            CMD_XOR: mod_row[bit_idx] = ~ram_q[bit_idx];
            default: ;
        endcase
    end

    assign busy       = (state != ST_IDLE) || !fifo_empty;
    assign cnt32      = 32'(fifo_count);
    assign count_disp = (cnt32 > 32'd7) ? 3'd7 : cnt32[2:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_CLEAR;
            row_cnt     <= '0;
            cur         <= '0;
            wr_row      <= '0;
            prev_toggle <= 1'b0;
            overflow    <= 1'b0;
            starve_cnt  <= '0;
            rd_valid    <= 1'b0;
            status      <= '0;
        end else begin
            prev_toggle <= pio_word[PIO_TOG];
            rd_valid    <= disp_win;
            status      <= {busy, overflow, collision, 2'b00, count_disp};
            if (capture && fifo_full && !pop) overflow <= 1'b1;
            if (!eng_need || eng_grant) starve_cnt <= '0;
            else                        starve_cnt <= starve_cnt + 1'b1;

            case (state)
                ST_IDLE: if (!fifo_empty) begin
                    cur <= fifo_cmd;
                    if (fifo_cmd.cmd == CMD_CLS) begin
                        state   <= ST_CLEAR;
                        row_cnt <= '0;
                    end else begin
                        state <= ST_RD;
                    end
                end
                ST_RD:  if (eng_grant) state <= ST_MOD;
                ST_MOD: begin
                    wr_row <= mod_row;
                    state  <= ST_WR;
                end
                ST_WR:  if (eng_grant) state <= ST_IDLE;
                ST_CLEAR: if (eng_grant) begin
                    if (row_cnt == 5'(FB_H - 1)) state   <= ST_IDLE;
                    else                         row_cnt <= row_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef VCHIP8_FB_COLLISION_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            collision <= 1'b0;
        else if (pop && fifo_cmd.cmd == CMD_CLS)
            collision <= 1'b0;
        else if (state == ST_MOD && cur.cmd == CMD_XOR && ram_q[bit_idx])
            collision <= 1'b1;
    end
`else
    assign collision = 1'b0;
`endif
endmodule
